alarm_chime: RTL and testbench



---
 rtl/alarm_chime.sv | 169 ++++++++++++++++
 tb/tb_alarm_chime.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_chime.sv
// Hourly chime and settable alarm driving the piezo buzzer from the running BCD time.
// Owns the debounced alarm-set and stop buttons.
module alarm_chime #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned LO_HZ      = 500,
  parameter int unsigned HI_HZ      = 1000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       CLK_50M,
  input  logic       CR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic       Alarm_EN,
  input  logic       Set_AlmMin,
  input  logic       Set_AlmHour,
  input  logic       Alarm_Stop,
  output logic [7:0] Alm_Hour,
  output logic [7:0] Alm_Min,
  output logic       Ringing,
  output logic       Buzzer
);

  localparam int unsigned LO_HALF  = CLK_HZ / (2 * LO_HZ);
  localparam int unsigned HI_HALF  = CLK_HZ / (2 * HI_HZ);
  localparam int unsigned LO_W     = $clog2(LO_HALF + 1);
  localparam int unsigned HI_W     = $clog2(HI_HALF + 1);
  localparam int unsigned DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RING_W   = $clog2(RING_SEC + 1);
  localparam int unsigned NBTN     = 3;
  localparam int unsigned BTN_MIN  = 0;
  localparam int unsigned BTN_HOUR = 1;
  localparam int unsigned BTN_STOP = 2;

  typedef enum logic {IDLE, RING} state_e;

  state_e            state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [7:0]        alm_hour_q, alm_hour_d;
  logic [7:0]        alm_min_q, alm_min_d;
  logic [7:0]        prev_sec_q, prev_sec_d;
  logic [DEB_W-1:0]  deb_cnt_q [NBTN];
  logic [DEB_W-1:0]  deb_cnt_d [NBTN];
  logic [NBTN-1:0]   deb_lvl_q, deb_lvl_d;
  logic [NBTN-1:0]   deb_prev_q, deb_prev_d;
  logic [NBTN-1:0]   evt_q, evt_d;
  logic [LO_W-1:0]   lo_cnt_q, lo_cnt_d;
  logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic              lo_q, lo_d;
  logic              hi_q, hi_d;
  logic              buzz_q, buzz_d;

  logic [NBTN-1:0]   raw;
  logic              tick, trigger, lo_chime, hi_chime;

  // BCD increment with wrap from `last` back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  assign raw = {Alarm_Stop, Set_AlmHour, Set_AlmMin};

  always_comb begin
    deb_lvl_d  = deb_lvl_q;
    deb_prev_d = deb_lvl_q;
    evt_d      = deb_lvl_q & ~deb_prev_q;
    for (int i = 0; i < NBTN; i++) begin
      deb_cnt_d[i] = '0;
      if (raw[i] != deb_lvl_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) deb_lvl_d[i] = raw[i];
        else                                        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end

    lo_cnt_d = lo_cnt_q + LO_W'(1);
    lo_d     = lo_q;
    if (lo_cnt_q == LO_W'(LO_HALF - 1)) begin
      lo_cnt_d = '0;
      lo_d     = ~lo_q;
    end
    hi_cnt_d = hi_cnt_q + HI_W'(1);
    hi_d     = hi_q;
    if (hi_cnt_q == HI_W'(HI_HALF - 1)) begin
      hi_cnt_d = '0;
      hi_d     = ~hi_q;
    end

    alm_min_d  = evt_q[BTN_MIN]  ? bcd_inc(alm_min_q, 8'h59)  : alm_min_q;
    alm_hour_d = evt_q[BTN_HOUR] ? bcd_inc(alm_hour_q, 8'h23) : alm_hour_q;

    prev_sec_d = Second;
    tick       = (Second != prev_sec_q);
    trigger    = tick && Alarm_EN && (Hour == alm_hour_q) && (Minute == alm_min_q)
                 && (Second == 8'h00);

    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      IDLE: begin
        if (trigger && !evt_q[BTN_STOP]) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end
      end
      RING: begin
        if (!Alarm_EN || evt_q[BTN_STOP]) begin
          state_d = IDLE;
        end else if (tick) begin
          ring_cnt_d = ring_cnt_q + RING_W'(1);
          if (ring_cnt_d == RING_W'(RING_SEC)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    lo_chime = (Minute == 8'h59) && ((Second == 8'h51) || (Second == 8'h53) ||
                                     (Second == 8'h55) || (Second == 8'h57));
    hi_chime = (Minute == 8'h00) && (Second == 8'h00);

    // Alarm beeps on even seconds and overrides both chimes.
    if (state_q == RING) buzz_d = hi_q & ~Second[0];
    else if (hi_chime)   buzz_d = hi_q;
    else if (lo_chime)   buzz_d = lo_q;
    else                 buzz_d = 1'b0;
  end

  always_ff @(posedge CLK_50M) begin
    if (CR) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      alm_hour_q <= 8'h00;
      alm_min_q  <= 8'h00;
      prev_sec_q <= 8'h00;
      for (int i = 0; i < NBTN; i++) deb_cnt_q[i] <= '0;
      deb_lvl_q  <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      lo_cnt_q   <= '0;
      hi_cnt_q   <= '0;
      lo_q       <= 1'b0;
      hi_q       <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
      prev_sec_q <= prev_sec_d;
      for (int i = 0; i < NBTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_prev_d;
      evt_q      <= evt_d;
      lo_cnt_q   <= lo_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      buzz_q     <= buzz_d;
    end
  end

  assign Alm_Hour = alm_hour_q;
  assign Alm_Min  = alm_min_q;
  assign Ringing  = (state_q == RING);
  assign Buzzer   = buzz_q;

endmodule

// File: tb/tb_alarm_chime.sv
// Randomized bench for alarm_chime: a cycle-level reference model built from the
// behavioural rules feeds a scoreboard that a separate monitor drains every cycle.
module tb_alarm_chime;

  localparam int unsigned CLK_HZ  = 2000;
  localparam int unsigned LO_HZ   = 500;
  localparam int unsigned HI_HZ   = 1000;
  localparam int unsigned DEB     = 4;
  localparam int unsigned RING    = 3;
  localparam int          LO_HALF = CLK_HZ / (2 * LO_HZ);
  localparam int          HI_HALF = CLK_HZ / (2 * HI_HZ);

  logic       clk = 1'b0;
  logic       cr;
  logic [7:0] hour, minute, second;
  logic       en;
  logic [2:0] btn;
  logic [7:0] alm_hour, alm_min;
  logic       ringing, buzzer;

  always #5 clk = ~clk;

  alarm_chime #(
    .CLK_HZ(CLK_HZ), .LO_HZ(LO_HZ), .HI_HZ(HI_HZ), .DEB_CYCLES(DEB), .RING_SEC(RING)
  ) dut (
    .CLK_50M(clk), .CR(cr), .Hour(hour), .Minute(minute), .Second(second),
    .Alarm_EN(en), .Set_AlmMin(btn[0]), .Set_AlmHour(btn[1]), .Alarm_Stop(btn[2]),
    .Alm_Hour(alm_hour), .Alm_Min(alm_min), .Ringing(ringing), .Buzzer(buzzer)
  );

  typedef struct {
    logic [7:0] ah;
    logic [7:0] am;
    logic       ring;
    logic       buzz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: alarm kept as plain integers, tones from cycle count.
  int          t;
  bit [DEB-1:0] hist [3];
  int          nsamp [3];
  bit          acc [3];
  bit          p1 [3];
  bit          p2 [3];
  int          m_hour, m_min, m_cnt;
  bit          m_ring, m_buzz;
  logic [7:0]  m_prev;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_step();
    exp_t e;
    bit   hi_t, lo_t, tick, stop_ev, hi_ch, lo_ch, n_ring;
    bit   rise [3];
    int   n_cnt;
    if (cr) begin
      t = 0; m_hour = 0; m_min = 0; m_cnt = 0; m_ring = 0; m_buzz = 0; m_prev = 8'h00;
      for (int i = 0; i < 3; i++) begin
        hist[i] = '0; nsamp[i] = 0; acc[i] = 0; p1[i] = 0; p2[i] = 0;
      end
    end else begin
      hi_t    = ((t / HI_HALF) % 2) == 1;
      lo_t    = ((t / LO_HALF) % 2) == 1;
      tick    = (second != m_prev);
      stop_ev = p2[2];
      hi_ch   = (minute == 8'h00) && (second == 8'h00);
      lo_ch   = (minute == 8'h59) && (second inside {8'h51, 8'h53, 8'h55, 8'h57});
      if (m_ring)     m_buzz = hi_t && !second[0];
      else if (hi_ch) m_buzz = hi_t;
      else if (lo_ch) m_buzz = lo_t;
      else            m_buzz = 0;

      n_ring = m_ring;
      n_cnt  = m_cnt;
      if (!m_ring) begin
        if (tick && en && hour == to_bcd(m_hour) && minute == to_bcd(m_min) &&
            second == 8'h00 && !stop_ev) begin
          n_ring = 1; n_cnt = 0;
        end
      end else if (!en || stop_ev) begin
        n_ring = 0;
      end else if (tick) begin
        n_cnt = m_cnt + 1;
        if (n_cnt == RING) n_ring = 0;
      end
      m_ring = n_ring;
      m_cnt  = n_cnt;

      if (p2[0]) m_min  = (m_min + 1) % 60;
      if (p2[1]) m_hour = (m_hour + 1) % 24;

      // A level is accepted once the last DEB samples all disagree with it.
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][DEB-2:0], btn[i]};
        nsamp[i]++;
        rise[i] = 0;
        if (nsamp[i] >= DEB &&
            (acc[i] ? (hist[i] == {DEB{1'b0}}) : (hist[i] == {DEB{1'b1}}))) begin
          acc[i]  = ~acc[i];
          rise[i] = acc[i];
        end
        p2[i] = p1[i];
        p1[i] = rise[i];
      end
      t++;
      m_prev = second;
    end
    e.ah = to_bcd(m_hour); e.am = to_bcd(m_min); e.ring = m_ring; e.buzz = m_buzz;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("alm_hour", alm_hour, e.ah);
      check("alm_min", alm_min, e.am);
      check("ringing", 8'(ringing), 8'(e.ring));
      check("buzzer", 8'(buzzer), 8'(e.buzz));
    end
  end

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int w, input int glitch);
    if (glitch > 0) begin
      btn[w] = 1'b1; repeat (glitch) cyc();
      btn[w] = 1'b0; repeat (2) cyc();
    end
    btn[w] = 1'b1; repeat (DEB + 2 + $urandom_range(0, 4)) cyc();
    btn[w] = 1'b0; repeat (DEB + 2 + $urandom_range(0, 4)) cyc();
  endtask

  task automatic step_to(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input int n);
    hour = h; minute = m; second = s;
    repeat (n) cyc();
  endtask

  initial begin
    logic [7:0] secs [6];
    logic [7:0] mins [3];
    secs = '{8'h00, 8'h01, 8'h02, 8'h51, 8'h53, 8'h59};
    mins = '{8'h59, 8'h00, 8'h30};

    cr = 1'b1; en = 1'b0; btn = '0; hour = 8'h00; minute = 8'h00; second = 8'h00;
    repeat (3) cyc();
    cr = 1'b0; cyc();

    // Glitch then a solid press: one minute step only.
    btn[0] = 1'b1; repeat (2) cyc();
    btn[0] = 1'b0; repeat (2) cyc();
    btn[0] = 1'b1; repeat (10) cyc();
    btn[0] = 1'b0; repeat (8) cyc();
    repeat (59) press(0, int'($urandom_range(0, 3)));
    repeat (24) press(1, int'($urandom_range(0, 3)));
    repeat (2) begin
      btn[1:0] = 2'b11; repeat (8) cyc();
      btn = '0;         repeat (8) cyc();
    end

    // Hourly chime across the top of the hour.
    cr = 1'b1; cyc(); cr = 1'b0;
    for (int s = 50; s <= 59; s++) step_to(8'h00, 8'h59, to_bcd(s), 8);
    step_to(8'h01, 8'h00, 8'h00, 8);
    step_to(8'h01, 8'h00, 8'h01, 8);

    // Alarm at 07:30 running to timeout.
    repeat (7) press(1, 0);
    repeat (30) press(0, 0);
    en = 1'b1;
    step_to(8'h07, 8'h29, 8'h58, 4);
    step_to(8'h07, 8'h29, 8'h59, 8);
    for (int s = 0; s <= 5; s++) step_to(8'h07, 8'h30, to_bcd(s), 8);

    // Stop press while ringing.
    step_to(8'h07, 8'h29, 8'h59, 8);
    step_to(8'h07, 8'h30, 8'h00, int'($urandom_range(1, 4)));
    press(2, 0);
    for (int s = 1; s <= 4; s++) step_to(8'h07, 8'h30, to_bcd(s), 8);

    // Stop event landing on the trigger cycle keeps the alarm idle.
    step_to(8'h07, 8'h29, 8'h59, 8);
    btn[2] = 1'b1; repeat (DEB + 1) cyc();
    step_to(8'h07, 8'h30, 8'h00, 8);
    btn[2] = 1'b0;
    step_to(8'h07, 8'h30, 8'h01, 8);

    // Alarm disabled mid-ring.
    step_to(8'h07, 8'h29, 8'h59, 8);
    step_to(8'h07, 8'h30, 8'h00, 8);
    step_to(8'h07, 8'h30, 8'h01, int'($urandom_range(1, 6)));
    en = 1'b0; repeat (4) cyc();
    en = 1'b1; repeat (4) cyc();

    // Random mix of time, enable and buttons.
    repeat (400) begin
      if ($urandom_range(0, 9) == 0)  en = ~en;
      if ($urandom_range(0, 3) == 0)  second = secs[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0)  minute = mins[$urandom_range(0, 2)];
      if ($urandom_range(0, 19) == 0) hour = ($urandom_range(0, 1) == 0) ? 8'h07 : 8'h00;
      if ($urandom_range(0, 7) == 0)  btn = 3'($urandom);
      cyc();
    end

    // Alarm and high chime together, then reset mid-ring.
    btn = '0; cr = 1'b1; repeat (2) cyc(); cr = 1'b0; en = 1'b1;
    step_to(8'h23, 8'h59, 8'h59, 6);
    step_to(8'h00, 8'h00, 8'h00, 8);
    step_to(8'h00, 8'h00, 8'h01, 8);
    step_to(8'h00, 8'h00, 8'h02, 3);
    cr = 1'b1; cyc();
    cr = 1'b0; repeat (6) cyc();

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
